fetch_ctrl: RTL and testbench

//  Fetch-stage sequencer for the pc register and instruction memory port. Issues one imem request per

---
 rtl/riscv_pkg.sv | 14 +
 rtl/fetch_ctrl_if.sv | 27 ++
 rtl/fetch_redirect_hold.sv | 67 ++++++
 rtl/fetch_ctrl.sv | 140 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and sizes used by fetch_ctrl, its interface and its sub-module.
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    HOLD
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch sequencer (master) and imem (slave).
interface fetch_ctrl_if;
  import riscv_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/fetch_redirect_hold.sv
// Pending-redirect capture (newest wins, cleared on commit) and the next-PC mux for the pc register.
// Build option FETCH_MISALIGN_TRAP_EN: misaligned redirect targets are replaced by TRAP_VEC.
module fetch_redirect_hold
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0010
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            commit_i,
  input  logic [XLEN-1:0] seq_pc_i,
  output logic            pend_o,
  output logic [XLEN-1:0] pc_next_o,
  output logic            redir_misalign_o
);

  logic            pend_q, pend_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            pend_mis_q, pend_mis_d;
  logic [XLEN-1:0] tgt_pc;
  logic            tgt_mis;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign tgt_mis = |redirect_pc_i[1:0];
  assign tgt_pc  = tgt_mis ? TRAP_VEC : redirect_pc_i;
`else
  logic unused_trap;
  assign unused_trap = ^{TRAP_VEC, redirect_pc_i[1:0]};
  assign tgt_mis     = 1'b0;
  assign tgt_pc      = {redirect_pc_i[XLEN-1:2], 2'b00};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
      pend_mis_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      pend_mis_q <= pend_mis_d;
    end
  end

  // A commit always consumes the pending redirect, including a redirect arriving that same cycle.
  always_comb begin
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    pend_mis_d = pend_mis_q;
    if (commit_i) begin
      pend_d = 1'b0;
    end else if (redirect_i) begin
      pend_d     = 1'b1;
      pend_pc_d  = tgt_pc;
      pend_mis_d = tgt_mis;
    end
  end

  always_comb begin
    pend_o           = pend_q | redirect_i;
    pc_next_o        = redirect_i ? tgt_pc  : (pend_q ? pend_pc_q : seq_pc_i);
    redir_misalign_o = redirect_i ? tgt_mis : pend_mis_q;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: one outstanding imem request, decode back-pressure and EX redirects.
// Build option FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect trap and misalign_o.
module fetch_ctrl
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  input  logic              stallD_i,
  fetch_ctrl_if.master      imem,
  output logic [XLEN-1:0]   pc_next_o,
  output logic              stallF_o,
  output logic              instr_valid_o,
  output logic [XLEN-1:0]   instr_o,
  output logic [XLEN-1:0]   instr_pc_o,
  output logic              flushD_o,
  output logic              misalign_o
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] hold_q, hold_d;
  logic [XLEN-1:0] seq_pc;
  logic            pend;
  logic            redir_mis;
  logic            commit;
  logic            redir_commit;

  // IDLE presents RESET_PC itself; elsewhere the sequential candidate is the next word.
  assign seq_pc = (state_q == IDLE) ? fetch_pc_q : fetch_pc_q + XLEN'(INSTR_BYTES);

  fetch_redirect_hold #(
    .TRAP_VEC (TRAP_VEC)
  ) u_redirect_hold (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .commit_i         (commit),
    .seq_pc_i         (seq_pc),
    .pend_o           (pend),
    .pc_next_o        (pc_next_o),
    .redir_misalign_o (redir_mis)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      hold_q     <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ:  if (imem.gnt) state_d = RESP;
      RESP: begin
        if (imem.rvalid) begin
          state_d = (pend || !stallD_i) ? REQ : HOLD;
        end
      end
      HOLD: if (pend || !stallD_i) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  // Fetched data is dropped whenever a redirect commits; the pc register only moves on commit.
  always_comb begin
    imem.req      = 1'b0;
    imem.addr     = '0;
    instr_valid_o = 1'b0;
    instr_o       = '0;
    instr_pc_o    = '0;
    commit        = 1'b0;
    redir_commit  = 1'b0;
    hold_d        = hold_q;
    unique case (state_q)
      REQ: begin
        imem.req  = 1'b1;
        imem.addr = fetch_pc_q;
      end
      RESP: begin
        if (imem.rvalid) begin
          if (pend) begin
            commit       = 1'b1;
            redir_commit = 1'b1;
          end else if (!stallD_i) begin
            instr_valid_o = 1'b1;
            instr_o       = imem.rdata;
            instr_pc_o    = fetch_pc_q;
            commit        = 1'b1;
          end else begin
            hold_d = imem.rdata;
          end
        end
      end
      HOLD: begin
        if (pend) begin
          commit       = 1'b1;
          redir_commit = 1'b1;
        end else begin
          instr_valid_o = 1'b1;
          instr_o       = hold_q;
          instr_pc_o    = fetch_pc_q;
          commit        = !stallD_i;
        end
      end
      default: ;
    endcase
    fetch_pc_d = commit ? pc_next_o : fetch_pc_q;
    stallF_o   = !commit;
    flushD_o   = redir_commit;
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= redir_commit & redir_mis;
  end

  assign misalign_o = misalign_q;
`else
  logic unused_mis;
  assign unused_mis = redir_mis;
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with a small imem model (grant delay, response latency).
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stallD_i;
  logic [31:0] pc_next_o;
  logic        stallF_o;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        flushD_o;
  logic        misalign_o;

  int checks = 0;
  int errors = 0;

  int          gnt_delay = 0;
  int          rv_lat    = 2;
  int          gnt_cnt   = 0;
  int          rv_timer  = 0;
  logic [31:0] rv_addr   = '0;
  logic [31:0] exp_tgt;
  logic        exp_mis;

  fetch_ctrl_if imem_bus ();

  fetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .stallD_i      (stallD_i),
    .imem          (imem_bus),
    .pc_next_o     (pc_next_o),
    .stallF_o      (stallF_o),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .flushD_o      (flushD_o),
    .misalign_o    (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // imem model: grant after gnt_delay request cycles, rvalid rv_lat cycles after grant; not reset by rst_n
  assign imem_bus.gnt    = imem_bus.req && (gnt_cnt >= gnt_delay);
  assign imem_bus.rvalid = (rv_timer == 1);
  assign imem_bus.rdata  = instrOf(rv_addr);

  always @(posedge clk) begin
    if (imem_bus.req && !imem_bus.gnt) gnt_cnt <= gnt_cnt + 1;
    else                               gnt_cnt <= 0;
    if (imem_bus.req && imem_bus.gnt) begin
      rv_timer <= rv_lat;
      rv_addr  <= imem_bus.addr;
    end else if (rv_timer != 0) begin
      rv_timer <= rv_timer - 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic stall);
    redirect_i    = redir;
    redirect_pc_i = rpc;
    stallD_i      = stall;
    #2;
  endtask

  // One undisturbed fetch of address a with response latency lat, ending on its commit cycle
  task automatic fetchSeq(input logic [31:0] a, input int lat, input logic [31:0] exp_next);
    rv_lat = lat;
    nextCycle;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("req", {31'b0, imem_bus.req}, 32'd1);
    checkOutput("addr", imem_bus.addr, a);
    checkOutput("stallF_req", {31'b0, stallF_o}, 32'd1);
    for (int i = 1; i < lat; i++) begin
      nextCycle;
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("valid_wait", {31'b0, instr_valid_o}, 32'd0);
      checkOutput("stallF_wait", {31'b0, stallF_o}, 32'd1);
    end
    nextCycle;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("valid_commit", {31'b0, instr_valid_o}, 32'd1);
    checkOutput("instr", instr_o, instrOf(a));
    checkOutput("instr_pc", instr_pc_o, a);
    checkOutput("stallF_commit", {31'b0, stallF_o}, 32'd0);
    checkOutput("pc_next_seq", pc_next_o, exp_next);
    checkOutput("flush_seq", {31'b0, flushD_o}, 32'd0);
  endtask

  initial begin
`ifdef FETCH_MISALIGN_TRAP_EN
    exp_tgt = 32'h0000_0010;
    exp_mis = 1'b1;
`else
    exp_tgt = 32'h0000_0100;
    exp_mis = 1'b0;
`endif
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("rst_req", {31'b0, imem_bus.req}, 32'd0);
    checkOutput("rst_pc_next", pc_next_o, 32'h0);
    checkOutput("rst_stallF", {31'b0, stallF_o}, 32'd1);
    checkOutput("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    checkOutput("rst_flush", {31'b0, flushD_o}, 32'd0);
    checkOutput("rst_misalign", {31'b0, misalign_o}, 32'd0);
    nextCycle;
    nextCycle;
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("idle_req", {31'b0, imem_bus.req}, 32'd0);
    checkOutput("idle_pc_next", pc_next_o, 32'h0);

    // sequential fetches, one commit every third cycle
    fetchSeq(32'h0, 2, 32'h4);
    fetchSeq(32'h4, 2, 32'h8);
    fetchSeq(32'h8, 2, 32'hC);

    // decode stall for four cycles starting at rvalid
    nextCycle;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("stall_addr", imem_bus.addr, 32'hC);
    nextCycle;
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("stall_wait_valid", {31'b0, instr_valid_o}, 32'd0);
    nextCycle;
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("stall_rv_valid", {31'b0, instr_valid_o}, 32'd0);
    checkOutput("stall_rv_stallF", {31'b0, stallF_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      nextCycle;
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("hold_valid", {31'b0, instr_valid_o}, 32'd1);
      checkOutput("hold_instr", instr_o, instrOf(32'hC));
      checkOutput("hold_pc", instr_pc_o, 32'hC);
      checkOutput("hold_stallF", {31'b0, stallF_o}, 32'd1);
    end
    nextCycle;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("release_valid", {31'b0, instr_valid_o}, 32'd1);
    checkOutput("release_stallF", {31'b0, stallF_o}, 32'd0);
    checkOutput("release_pc_next", pc_next_o, 32'h10);

    // redirect while waiting for the response
    nextCycle;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("redir_req_addr", imem_bus.addr, 32'h10);
    nextCycle;
    applyStimulus(1'b1, 32'h100, 1'b0);
    checkOutput("redir_pulse_pc_next", pc_next_o, 32'h100);
    checkOutput("redir_pulse_stallF", {31'b0, stallF_o}, 32'd1);
    nextCycle;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("redir_flush", {31'b0, flushD_o}, 32'd1);
    checkOutput("redir_valid", {31'b0, instr_valid_o}, 32'd0);
    checkOutput("redir_stallF", {31'b0, stallF_o}, 32'd0);
    checkOutput("redir_pc_next", pc_next_o, 32'h100);

    // two redirects during a slow grant: request held, newest target wins
    gnt_delay = 3;
    nextCycle;
    applyStimulus(1'b1, 32'h200, 1'b0);
    checkOutput("slow_addr0", imem_bus.addr, 32'h100);
    nextCycle;
    applyStimulus(1'b1, 32'h300, 1'b0);
    checkOutput("slow_addr1", imem_bus.addr, 32'h100);
    nextCycle;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("slow_req2", {31'b0, imem_bus.req}, 32'd1);
    checkOutput("slow_pend_pc", pc_next_o, 32'h300);
    nextCycle;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("slow_req3", {31'b0, imem_bus.req}, 32'd1);
    gnt_delay = 0;
    nextCycle;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("slow_wait_valid", {31'b0, instr_valid_o}, 32'd0);
    nextCycle;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("slow_flush", {31'b0, flushD_o}, 32'd1);
    checkOutput("slow_pc_next", pc_next_o, 32'h300);

    // misaligned redirect arriving in the same cycle as rvalid
    nextCycle;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("mis_req_addr", imem_bus.addr, 32'h300);
    nextCycle;
    applyStimulus(1'b0, 32'h0, 1'b0);
    nextCycle;
    applyStimulus(1'b1, 32'h102, 1'b0);
    checkOutput("mis_flush", {31'b0, flushD_o}, 32'd1);
    checkOutput("mis_valid", {31'b0, instr_valid_o}, 32'd0);
    checkOutput("mis_stallF", {31'b0, stallF_o}, 32'd0);
    checkOutput("mis_pc_next", pc_next_o, exp_tgt);
    checkOutput("mis_flag_commit", {31'b0, misalign_o}, 32'd0);
    nextCycle;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("mis_addr", imem_bus.addr, exp_tgt);
    checkOutput("mis_flag", {31'b0, misalign_o}, {31'b0, exp_mis});

    // redirect to the top word, then sequential wrap to zero
    nextCycle;
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0);
    checkOutput("mis_flag_gone", {31'b0, misalign_o}, 32'd0);
    checkOutput("top_pc_next", pc_next_o, 32'hFFFF_FFFC);
    nextCycle;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("top_flush", {31'b0, flushD_o}, 32'd1);
    fetchSeq(32'hFFFF_FFFC, 2, 32'h0);

    // reset mid-response, late rvalid lands in IDLE
    nextCycle;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("wrap_addr", imem_bus.addr, 32'h0);
    nextCycle;
    applyStimulus(1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_req", {31'b0, imem_bus.req}, 32'd0);
    checkOutput("midrst_stallF", {31'b0, stallF_o}, 32'd1);
    checkOutput("midrst_pc_next", pc_next_o, 32'h0);
    nextCycle;
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("late_rvalid", {31'b0, imem_bus.rvalid}, 32'd1);
    checkOutput("late_valid", {31'b0, instr_valid_o}, 32'd0);
    checkOutput("late_stallF", {31'b0, stallF_o}, 32'd1);
    checkOutput("late_req", {31'b0, imem_bus.req}, 32'd0);
    fetchSeq(32'h0, 1, 32'h4);
    fetchSeq(32'h4, 1, 32'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
